// File: rtl/pipe_pkg.sv
// Shared constants and width helpers for the elastic pipeline stage family.
package pipe_pkg;

  localparam int unsigned MAX_DEPTH = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Counter must represent 0..DEPTH+2*SKID_EN inclusive.
  function automatic int unsigned occ_width(input int unsigned depth, input int unsigned skid_en);
    return clog2(depth + 2 * skid_en + 1);
  endfunction

endpackage

// File: rtl/pipe_elastic_stage.sv
// One elastic register slot: a valid bit plus payload, with load, pop and clear control.
module pipe_elastic_stage #(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              load,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Clear drops only the valid bit; payload keeps its last value.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid <= 1'b0;
      data  <= PRESET_VAL;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Chain of DEPTH elastic stages with optional 2-entry skid buffer, flush, stall and occupancy.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter int unsigned       DEPTH      = 2,
  parameter int unsigned       SKID_EN    = 1,
  parameter logic [DATA_W-1:0] PRESET_VAL = '0,
  localparam int unsigned      CNT_W      = occ_width(DEPTH, SKID_EN)
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  logic                         go;
  logic [DEPTH-1:0]             v;
  logic [DEPTH:0]               vin;
  logic [DEPTH-1:0]             rdy;
  logic [DEPTH:0]               ld;
  logic [DEPTH:0][DATA_W-1:0]   dchain;
  logic                         sink_pop;
  logic                         in_fire;
  logic                         out_fire;

  assign go        = en & ~flush & ~srst;
  assign vin       = {v, in_valid};
  assign dchain[0] = in_data;

  // ld[i] loads stage i; ld[DEPTH] is the last stage draining into the sink.
  always_comb begin
    ld        = '0;
    rdy       = '0;
    ld[DEPTH] = sink_pop;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy[i] = ~v[i] | ld[i+1];
      ld[i]  = go & vin[i] & rdy[i];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_elastic_stage #(
      .DATA_W     (DATA_W),
      .PRESET_VAL (PRESET_VAL)
    ) u_stage (
      .clk       (clk),
      .srst      (srst),
      .load      (ld[i]),
      .pop       (ld[i+1]),
      .clear     (flush),
      .load_data (dchain[i]),
      .valid     (v[i]),
      .data      (dchain[i+1])
    );
  end

  assign in_ready = go & rdy[0];
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  if (SKID_EN != 0) begin : g_skid
    logic              m_v, s_v;
    logic [DATA_W-1:0] m_d, s_d;

    // Readiness toward the chain depends only on registered s_v, cutting out_ready -> in_ready.
    assign sink_pop  = go & v[DEPTH-1] & ~s_v;
    assign out_valid = en & ~srst & m_v;
    assign out_data  = m_d;

    always_ff @(posedge clk) begin
      if (srst) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
        m_d <= PRESET_VAL;
        s_d <= PRESET_VAL;
      end else if (flush) begin
        m_v <= 1'b0;
        s_v <= 1'b0;
      end else if (en) begin
        if (out_fire) begin
          if (s_v) begin
            m_d <= s_d;
            s_v <= 1'b0;
          end else if (sink_pop) begin
            m_d <= dchain[DEPTH];
          end else begin
            m_v <= 1'b0;
          end
        end else if (sink_pop) begin
          if (m_v) begin
            s_v <= 1'b1;
            s_d <= dchain[DEPTH];
          end else begin
            m_v <= 1'b1;
            m_d <= dchain[DEPTH];
          end
        end
      end
    end
  end else begin : g_noskid
    assign out_valid = en & ~srst & v[DEPTH-1];
    assign out_data  = dchain[DEPTH];
    assign sink_pop  = out_fire;
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      occupancy <= '0;
    end else if (en) begin
      occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: skid config (DEPTH=2) and minimal config (DEPTH=1).
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int unsigned AW       = occ_width(2, 1);
  localparam int unsigned BW       = occ_width(1, 0);
  localparam logic [63:0] A_PRESET = 64'h5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic          a_srst, a_en, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [63:0]   a_in_data, a_out_data;
  logic [AW-1:0] a_occ;
  logic          b_srst, b_en, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]   b_in_data, b_out_data;
  logic [BW-1:0] b_occ;

  pipe_stage_elastic #(
    .DATA_W(64), .DEPTH(2), .SKID_EN(1), .PRESET_VAL(A_PRESET)
  ) u_dut_a (
    .clk(clk), .srst(a_srst), .en(a_en), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ)
  );

  pipe_stage_elastic #(
    .DATA_W(16), .DEPTH(1), .SKID_EN(0), .PRESET_VAL(16'h0)
  ) u_dut_b (
    .clk(clk), .srst(b_srst), .en(b_en), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ)
  );

  logic [63:0] qa[$];
  logic [15:0] qb[$];
  int          cyc;
  int          a_lat_in, a_lat_out, a_out_cnt, a_gaps, a_prev_out;
  int          b_lat_in, b_lat_out, b_out_cnt;
  logic [63:0] a_first_out;
  logic        a_in_fire, b_in_fire;
  bit          armed = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      assert (a_occ <= AW'(4)) else $error("occupancy above capacity: %0d", a_occ);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic reset_stats();
    a_lat_in  = -1;
    a_lat_out = -1;
    a_out_cnt = 0;
    a_gaps    = 0;
    a_prev_out = -1;
    b_lat_in  = -1;
    b_lat_out = -1;
    b_out_cnt = 0;
  endtask

  // Sample handshakes mid-cycle, update scoreboards, then advance one clock.
  task automatic tick();
    logic [63:0] ea;
    logic [15:0] eb;
    @(negedge clk);
    a_in_fire = a_in_valid & a_in_ready;
    b_in_fire = b_in_valid & b_in_ready;
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check_eq("a_unexpected_out", 64'(qa.size()), 64'd1);
      end else begin
        ea = qa.pop_front();
        check_eq("a_order", a_out_data, ea);
      end
      if (a_lat_out < 0) a_lat_out = cyc;
      if (a_out_cnt > 0 && a_prev_out != cyc - 1) a_gaps++;
      if (a_out_cnt == 0) a_first_out = a_out_data;
      a_out_cnt++;
      a_prev_out = cyc;
    end
    if (a_in_fire) begin
      qa.push_back(a_in_data);
      if (a_lat_in < 0) a_lat_in = cyc;
    end
    if (a_srst || a_flush) qa.delete();
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        check_eq("b_unexpected_out", 64'(qb.size()), 64'd1);
      end else begin
        eb = qb.pop_front();
        check_eq("b_order", 64'(b_out_data), 64'(eb));
      end
      if (b_lat_out < 0) b_lat_out = cyc;
      b_out_cnt++;
    end
    if (b_in_fire) begin
      qb.push_back(b_in_data);
      if (b_lat_in < 0) b_lat_in = cyc;
    end
    if (b_srst || b_flush) qb.delete();
    @(posedge clk);
    cyc++;
    #1;
    check_eq("a_occ_model", 64'(a_occ), 64'(qa.size()));
    check_eq("b_occ_model", 64'(b_occ), 64'(qb.size()));
  endtask

  initial begin
    int          idx;
    int          n;
    logic [AW-1:0] hold;

    a_srst = 1'b1; a_en = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    a_out_ready = 1'b0;
    b_srst = 1'b1; b_en = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    b_out_ready = 1'b0;
    cyc = 0;
    reset_stats();
    tick();
    tick();
    a_srst = 1'b0;
    #1;
    check_eq("rst_in_ready", 64'(a_in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
    check_eq("rst_out_data", a_out_data, A_PRESET);
    check_eq("rst_occ", 64'(a_occ), 64'd0);
    armed = 1'b1;

    // Streaming: 8 back-to-back items with free output.
    reset_stats();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'(i);
      tick();
      check_eq("stream_accept", 64'(a_in_fire), 64'd1);
      if (i >= 3) check_eq("stream_occ", 64'(a_occ), 64'd3);
    end
    a_in_valid = 1'b0;
    for (int k = 0; k < 20 && qa.size() > 0; k++) tick();
    check_eq("stream_drain", 64'(qa.size()), 64'd0);
    check_eq("stream_latency", 64'(a_lat_out - a_lat_in), 64'd3);
    check_eq("stream_gaps", 64'(a_gaps), 64'd0);
    check_eq("stream_count", 64'(a_out_cnt), 64'd8);
    check_eq("stream_first", a_first_out, 64'h1);

    // Backpressure: fill to capacity, then release.
    reset_stats();
    a_out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'hA0 + 64'(idx);
      tick();
      if (a_in_fire) idx++;
    end
    check_eq("bp_accepts", 64'(idx), 64'd4);
    check_eq("bp_in_ready", 64'(a_in_ready), 64'd0);
    check_eq("bp_occ", 64'(a_occ), 64'd4);
    check_eq("bp_out_valid", 64'(a_out_valid), 64'd1);
    a_out_ready = 1'b1;
    for (int k = 0; k < 40 && (idx < 6 || qa.size() > 0); k++) begin
      a_in_valid = (idx < 6);
      a_in_data  = 64'hA0 + 64'(idx);
      tick();
      if (a_in_fire) idx++;
    end
    a_in_valid = 1'b0;
    check_eq("bp_total_in", 64'(idx), 64'd6);
    check_eq("bp_delivered", 64'(a_out_cnt), 64'd6);
    check_eq("bp_first", a_first_out, 64'hA0);

    // Flush with three entries held.
    reset_stats();
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'h31 + 64'(k);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (3) tick();
    check_eq("fl_occ_before", 64'(a_occ), 64'd3);
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 64'h99;
    #1;
    check_eq("fl_in_ready", 64'(a_in_ready), 64'd0);
    check_eq("fl_out_valid_during", 64'(a_out_valid), 64'd1);
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check_eq("fl_occ_after", 64'(a_occ), 64'd0);
    check_eq("fl_out_valid_after", 64'(a_out_valid), 64'd0);
    a_out_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 30 && (idx < 2 || qa.size() > 0); k++) begin
      a_in_valid = (idx < 2);
      a_in_data  = 64'h55 + 64'(idx);
      tick();
      if (a_in_fire) idx++;
    end
    a_in_valid = 1'b0;
    check_eq("fl_first_out", a_first_out, 64'h55);
    check_eq("fl_count", 64'(a_out_cnt), 64'd2);

    // Stall: en low for 5 cycles mid-burst.
    reset_stats();
    a_out_ready = 1'b1;
    idx = 0;
    for (int k = 0; k < 60 && (idx < 10 || qa.size() > 0); k++) begin
      if (k == 6) begin
        a_en       = 1'b0;
        a_in_valid = 1'b1;
        #1;
        hold = a_occ;
        for (int s = 0; s < 5; s++) begin
          check_eq("stall_in_ready", 64'(a_in_ready), 64'd0);
          check_eq("stall_out_valid", 64'(a_out_valid), 64'd0);
          tick();
          check_eq("stall_occ", 64'(a_occ), 64'(hold));
        end
        a_en = 1'b1;
      end
      a_in_valid = (idx < 10);
      a_in_data  = 64'h61 + 64'(idx);
      tick();
      if (a_in_fire) idx++;
    end
    a_in_valid = 1'b0;
    check_eq("stall_total_in", 64'(idx), 64'd10);
    check_eq("stall_delivered", 64'(a_out_cnt), 64'd10);
    check_eq("stall_first", a_first_out, 64'h61);

    // Reset mid-operation.
    reset_stats();
    a_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_in_valid = 1'b1;
      a_in_data  = 64'hC1 + 64'(k);
      tick();
    end
    a_in_valid = 1'b0;
    repeat (2) tick();
    check_eq("mr_occ_before", 64'(a_occ), 64'd3);
    a_srst      = 1'b1;
    a_in_valid  = 1'b1;
    a_out_ready = 1'b1;
    #1;
    check_eq("mr_in_ready_forced", 64'(a_in_ready), 64'd0);
    check_eq("mr_out_valid_forced", 64'(a_out_valid), 64'd0);
    tick();
    a_srst     = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check_eq("mr_occ_after", 64'(a_occ), 64'd0);
    check_eq("mr_out_valid_after", 64'(a_out_valid), 64'd0);
    check_eq("mr_out_data", a_out_data, A_PRESET);
    check_eq("mr_none_out", 64'(a_out_cnt), 64'd0);

    // Minimal config: DEPTH=1, no skid.
    reset_stats();
    b_srst      = 1'b0;
    b_out_ready = 1'b1;
    #1;
    check_eq("b_rst_in_ready", 64'(b_in_ready), 64'd1);
    check_eq("b_rst_out_valid", 64'(b_out_valid), 64'd0);
    check_eq("b_rst_out_data", 64'(b_out_data), 64'd0);
    b_in_valid = 1'b1;
    b_in_data  = 16'hB000;
    tick();
    check_eq("b_first_accept", 64'(b_in_fire), 64'd1);
    b_in_valid = 1'b0;
    tick();
    check_eq("b_latency", 64'(b_lat_out - b_lat_in), 64'd1);
    n = 1;
    for (int j = 0; j < 12; j++) begin
      b_out_ready = (j % 2 == 0);
      b_in_valid  = 1'b1;
      b_in_data   = 16'hB000 + 16'(n);
      #1;
      if (b_out_valid) check_eq("b_ready_follow", 64'(b_in_ready), 64'(b_out_ready));
      tick();
      if (b_in_fire) n++;
    end
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    for (int k = 0; k < 10 && qb.size() > 0; k++) tick();
    check_eq("b_drain", 64'(qb.size()), 64'd0);
    check_eq("b_pushes", 64'(n), 64'd7);
    check_eq("b_delivered", 64'(b_out_cnt), 64'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
